au_chain_scheduler: RTL

//  Sample-rate pacer and flow controller between the audio interface source stream and the LPF->HPF

---
 rtl/au_chain_scheduler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/au_chain_scheduler.sv
// au_chain_scheduler
// Paces audio samples from the interface stream into the LPF->HPF cascade.
// One sample is released per programmable tick. A credit counter, fed by the
// cascade output handshake, limits how many samples are in flight. Underrun,
// overrun and late-issue events are counted and raise a one-cycle interrupt.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   enable_i, div_i, clear_i      control: enable, tick period minus 1, counter clear
//   src_data_i/valid_i/ready_o    source stream (ready_o is the accept strobe)
//   chain_data_o/valid_o/ready_i  stream into the cascade
//   ret_valid_i, ret_ready_i      cascade output handshake (observed only)
//   in_flight_o                   samples currently inside the cascade
//   sample/underrun/overrun/late_cnt_o  saturating event counters
//   irq_o                         registered pulse after any error event
module au_chain_scheduler #(
    parameter int DataWidth   = 32,
    parameter int DivWidth    = 16,
    parameter int MaxInFlight = 4,
    parameter int CntWidth    = 16,
    localparam int IfWidth    = $clog2(MaxInFlight + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [DivWidth-1:0]  div_i,
    input  logic                 clear_i,
    input  logic [DataWidth-1:0] src_data_i,
    input  logic                 src_valid_i,
    output logic                 src_ready_o,
    output logic [DataWidth-1:0] chain_data_o,
    output logic                 chain_valid_o,
    input  logic                 chain_ready_i,
    input  logic                 ret_valid_i,
    input  logic                 ret_ready_i,
    output logic [IfWidth-1:0]   in_flight_o,
    output logic [CntWidth-1:0]  sample_cnt_o,
    output logic [CntWidth-1:0]  underrun_cnt_o,
    output logic [CntWidth-1:0]  overrun_cnt_o,
    output logic [CntWidth-1:0]  late_cnt_o,
    output logic                 irq_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ISSUE} state_t;

    localparam logic [IfWidth-1:0] IfMax = IfWidth'(MaxInFlight);

    // Event vector index: 0 sample issued, 1 underrun, 2 overrun, 3 late
    localparam int NumCnt = 4;

    state_t                 state_q;
    logic [DivWidth-1:0]    tick_cnt_q;
    logic [DataWidth-1:0]   data_q;
    logic [IfWidth-1:0]     in_flight_q;
    logic [IfWidth-1:0]     in_flight_d;
    logic                   irq_q;

    logic                   running;
    logic                   tick;
    logic                   credits_full;
    logic                   accept;
    logic                   chain_hs;
    logic                   ret_hs;
    logic [NumCnt-1:0]      events;
    logic [NumCnt*CntWidth-1:0] cnt_flat;

    // The divider only advances while enabled and out of IDLE, so leaving IDLE
    // always starts a fresh period from 0.
    assign running      = enable_i && (state_q != ST_IDLE);
    assign tick         = running && (tick_cnt_q == div_i);
    assign credits_full = (in_flight_q == IfMax);
    assign accept       = (state_q == ST_WAIT) && tick && !credits_full && src_valid_i;
    assign chain_hs     = (state_q == ST_ISSUE) && chain_ready_i;
    // A return while nothing is in flight is ignored.
    assign ret_hs       = ret_valid_i && ret_ready_i && (in_flight_q != '0);

    assign events[0] = chain_hs;
    assign events[1] = (state_q == ST_WAIT) && tick && !credits_full && !src_valid_i;
    assign events[2] = (state_q == ST_WAIT) && tick && credits_full;
    assign events[3] = (state_q == ST_ISSUE) && tick && !chain_hs;

    always_comb begin
        in_flight_d = in_flight_q;
        case ({chain_hs, ret_hs})
            2'b10:   in_flight_d = in_flight_q + IfWidth'(1);
            2'b01:   in_flight_d = in_flight_q - IfWidth'(1);
            default: in_flight_d = in_flight_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            data_q      <= '0;
            in_flight_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            in_flight_q <= in_flight_d;
            irq_q       <= |events[3:1];

            if (!running || tick) begin
                tick_cnt_q <= '0;
            end else begin
                tick_cnt_q <= tick_cnt_q + DivWidth'(1);
            end

            if (accept) begin
                data_q <= src_data_i;
            end

            case (state_q)
                ST_IDLE: begin
                    if (enable_i) state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!enable_i)   state_q <= ST_IDLE;
                    else if (accept) state_q <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    // Valid is never withdrawn; enable only picks the state after the handshake.
                    if (chain_hs) state_q <= enable_i ? ST_WAIT : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Saturating event counters; clear has priority over a coincident increment.
    generate
        for (genvar gi = 0; gi < NumCnt; gi++) begin : g_cnt
            logic [CntWidth-1:0] cnt_q;
            logic [CntWidth-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clear_i) begin
                    cnt_d = '0;
                end else if (events[gi] && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_flat[gi*CntWidth +: CntWidth] = cnt_q;
        end
    endgenerate

    assign src_ready_o    = accept;
    assign chain_valid_o  = (state_q == ST_ISSUE);
    assign chain_data_o   = data_q;
    assign in_flight_o    = in_flight_q;
    assign irq_o          = irq_q;
    assign sample_cnt_o   = cnt_flat[0*CntWidth +: CntWidth];
    assign underrun_cnt_o = cnt_flat[1*CntWidth +: CntWidth];
    assign overrun_cnt_o  = cnt_flat[2*CntWidth +: CntWidth];
    assign late_cnt_o     = cnt_flat[3*CntWidth +: CntWidth];

endmodule
